// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding,
// requester IDs and default widths.
package dmem_arb_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    // Requester IDs, also used as the winner id and last-winner pointer value.
    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_AUX = 1'b1;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The grant is combinational from req and the
// last-winner pointer; the pointer advances whenever a grant is issued.
// On a tie the port that did not win last time is granted.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic       winner
);
    import dmem_arb_pkg::*;

    logic last;

    // Pick the winner for this cycle from the request pattern and the pointer.
    always_comb begin
        gnt    = 2'b00;
        winner = REQ_CPU;
        case (req)
            2'b01: begin
                gnt    = 2'b01;
                winner = REQ_CPU;
            end
            2'b10: begin
                gnt    = 2'b10;
                winner = REQ_AUX;
            end
            2'b11: begin
                if (last == REQ_AUX) begin
                    gnt    = 2'b01;
                    winner = REQ_CPU;
                end else begin
                    gnt    = 2'b10;
                    winner = REQ_AUX;
                end
            end
            default: begin
                gnt    = 2'b00;
                winner = REQ_CPU;
            end
        endcase
    end

    // Remember who won; reset points at AUX so the CPU wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last <= REQ_AUX;
        end else if (gnt != 2'b00) begin
            last <= winner;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one asynchronous-read / synchronous-write data memory between the
// CPU port (0) and the I/O/loader port (1). After reset an optional sweep
// writes zero to every location before any requester is served.
// Handshake: a requester raises req with w/addr/wdata and holds them stable
// until it sees gnt in the same cycle; the access happens in that gnt cycle.
// For reads, rdata is loaded at the end of the gnt cycle and rvalid pulses
// for the following cycle; rdata then holds until the next granted read.
module dmem_arbiter #(
    parameter int ADDR_W         = dmem_arb_pkg::ADDR_W,
    parameter int DATA_W         = dmem_arb_pkg::DATA_W,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_req,
    input  logic              r0_w,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_gnt,
    output logic              r0_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_req,
    input  logic              r1_w,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              init_busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_w,
    input  logic [DATA_W-1:0] mem_data_out
);
    import dmem_arb_pkg::*;

    arb_state_t        state;
    logic [ADDR_W-1:0] cnt;
    logic              run_en;
    logic [1:0]        arb_req;
    logic [1:0]        arb_gnt;
    logic              winner;
    logic              rd0_take;
    logic              rd1_take;

    // Requests only reach the arbiter in RUN and never while reset is held.
    assign run_en   = (state == ST_RUN) && !rst;
    assign arb_req  = run_en ? {r1_req, r0_req} : 2'b00;
    assign r0_gnt   = arb_gnt[0];
    assign r1_gnt   = arb_gnt[1];
    assign rd0_take = arb_gnt[0] & ~r0_w;
    assign rd1_take = arb_gnt[1] & ~r1_w;
    assign init_busy = (state == ST_CLEAR);

    rr_arb2 u_rr_arb2 (
        .clk    (clk),
        .rst    (rst),
        .req    (arb_req),
        .gnt    (arb_gnt),
        .winner (winner)
    );

    // CLEAR/RUN sequencing: the sweep walks every address once, then RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            cnt   <= '0;
        end else if (state == ST_CLEAR) begin
            cnt <= cnt + 1'b1;
            if (cnt == {ADDR_W{1'b1}}) begin
                state <= ST_RUN;
            end
        end
    end

    // Memory-side mux: sweep write, granted port, or a quiet idle cycle.
    always_comb begin
        mem_w       = 1'b0;
        mem_addr    = r0_addr;
        mem_data_in = '0;
        if (!rst && state == ST_CLEAR) begin
            mem_w    = 1'b1;
            mem_addr = cnt;
        end else if (arb_gnt != 2'b00) begin
            if (winner == REQ_AUX) begin
                mem_addr    = r1_addr;
                mem_w       = r1_w;
                mem_data_in = r1_w ? r1_wdata : '0;
            end else begin
                mem_addr    = r0_addr;
                mem_w       = r0_w;
                mem_data_in = r0_w ? r0_wdata : '0;
            end
        end
    end

    // Read return: capture the asynchronous read at the end of the grant cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r0_rvalid <= 1'b0;
            r0_rdata  <= '0;
            r1_rvalid <= 1'b0;
            r1_rdata  <= '0;
        end else begin
            r0_rvalid <= rd0_take;
            r1_rvalid <= rd1_take;
            if (rd0_take) begin
                r0_rdata <= mem_data_out;
            end
            if (rd1_take) begin
                r1_rdata <= mem_data_out;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a behavioural 256x8 memory on the memory pins,
// directed scenarios plus a randomized run checked against a reference model.
module tb_dmem_arbiter;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int DEPTH = 256;

  // ---------------- clock / reset block ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          r0_req, r0_w, r1_req, r1_w;
  logic [AW-1:0] r0_addr, r1_addr;
  logic [DW-1:0] r0_wdata, r1_wdata;
  logic          r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
  logic [DW-1:0] r0_rdata, r1_rdata;
  logic          init_busy, mem_w;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data_in, mem_data_out;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_w(r0_w), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_w(r1_w), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .init_busy(init_busy), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_w(mem_w), .mem_data_out(mem_data_out)
  );

  // Behavioural data_memory: asynchronous read, write on posedge.
  logic [DW-1:0] tb_mem [DEPTH];
  always @(posedge clk) if (mem_w) tb_mem[mem_addr] <= mem_data_in;
  assign mem_data_out = tb_mem[mem_addr];

  int n_checks = 0;
  int n_pass = 0;

  // ---------------- reference model ----------------
  logic [DW-1:0] ref_mem [DEPTH];
  bit            ref_last;      // id of the port that won most recently
  bit            exp_g0, exp_g1;
  bit            exp_rv0, exp_rv1;
  logic [DW-1:0] exp_rd0, exp_rd1;
  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];

  task automatic model_reset();
    ref_last = 1'b1;
    exp_rv0 = 1'b0; exp_rv1 = 1'b0;
    exp_rd0 = '0;   exp_rd1 = '0;
  endtask

  task automatic model_zero_mem();
    for (int a = 0; a < DEPTH; a++) ref_mem[a] = '0;
  endtask

  // Who gets the memory this cycle: a lone requester, or on a tie whoever
  // did not win last time.
  task automatic model_eval();
    exp_g0 = 1'b0; exp_g1 = 1'b0;
    if (r0_req && r1_req) begin
      if (ref_last == 1'b1) exp_g0 = 1'b1; else exp_g1 = 1'b1;
    end else if (r0_req) exp_g0 = 1'b1;
    else if (r1_req) exp_g1 = 1'b1;
  endtask

  // Effect of the clock edge that ends the current cycle.
  task automatic model_commit();
    exp_rv0 = exp_g0 && !r0_w;
    exp_rv1 = exp_g1 && !r1_w;
    if (exp_rv0) exp_rd0 = ref_mem[r0_addr];
    if (exp_rv1) exp_rd1 = ref_mem[r1_addr];
    if (exp_g0 && r0_w) ref_mem[r0_addr] = r0_wdata;
    if (exp_g1 && r1_w) ref_mem[r1_addr] = r1_wdata;
    if (exp_g0) ref_last = 1'b0;
    if (exp_g1) ref_last = 1'b1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive0(input logic req, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    r0_req = req; r0_w = w; r0_addr = a; r0_wdata = d;
  endtask

  task automatic drive1(input logic req, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    r1_req = req; r1_w = w; r1_addr = a; r1_wdata = d;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    drive0(1'b1, 1'b1, 8'h05, 8'hEE);
    drive1(1'b1, 1'b1, 8'h06, 8'hDD);
    next_cycle();
    model_reset();
    n_checks++; if (r0_gnt !== 1'b0) $display("FAIL reset_r0_gnt: got %0b want 0", r0_gnt); else n_pass++;
    n_checks++; if (r1_gnt !== 1'b0) $display("FAIL reset_r1_gnt: got %0b want 0", r1_gnt); else n_pass++;
    n_checks++; if (mem_w !== 1'b0) $display("FAIL reset_mem_w: got %0b want 0", mem_w); else n_pass++;
    n_checks++; if (r0_rvalid !== 1'b0) $display("FAIL reset_r0_rvalid: got %0b want 0", r0_rvalid); else n_pass++;
    n_checks++; if (r1_rvalid !== 1'b0) $display("FAIL reset_r1_rvalid: got %0b want 0", r1_rvalid); else n_pass++;
    n_checks++; if (r0_rdata !== 8'h00) $display("FAIL reset_r0_rdata: got %0h want 0", r0_rdata); else n_pass++;
    n_checks++; if (r1_rdata !== 8'h00) $display("FAIL reset_r1_rdata: got %0h want 0", r1_rdata); else n_pass++;
  endtask

  task automatic test_clear_sweep();
    rst = 1'b0;
    drive0(1'b1, 1'b0, 8'h00, 8'h00);
    drive1(1'b0, 1'b0, 8'h00, 8'h00);
    #1;
    for (int i = 0; i < DEPTH; i++) begin
      n_checks++; if (init_busy !== 1'b1) $display("FAIL sweep_busy[%0d]: got %0b want 1", i, init_busy); else n_pass++;
      n_checks++; if (mem_w !== 1'b1) $display("FAIL sweep_mem_w[%0d]: got %0b want 1", i, mem_w); else n_pass++;
      n_checks++; if (mem_addr !== AW'(i)) $display("FAIL sweep_addr[%0d]: got %0h want %0h", i, mem_addr, i); else n_pass++;
      n_checks++; if (mem_data_in !== 8'h00) $display("FAIL sweep_data[%0d]: got %0h want 0", i, mem_data_in); else n_pass++;
      n_checks++; if (r0_gnt !== 1'b0) $display("FAIL sweep_no_gnt[%0d]: got %0b want 0", i, r0_gnt); else n_pass++;
      @(posedge clk);
      #2;
    end
    // cycle 257: the held request is finally served
    model_zero_mem();
    model_eval();
    n_checks++; if (init_busy !== 1'b0) $display("FAIL sweep_done_busy: got %0b want 0", init_busy); else n_pass++;
    n_checks++; if (r0_gnt !== 1'b1) $display("FAIL sweep_first_gnt: got %0b want 1", r0_gnt); else n_pass++;
    n_checks++; if (mem_w !== 1'b0) $display("FAIL sweep_first_mem_w: got %0b want 0", mem_w); else n_pass++;
    model_commit();
    next_cycle();
  endtask

  task automatic test_write_read();
    drive0(1'b1, 1'b1, 8'h10, 8'hA5);
    drive1(1'b0, 1'b0, 8'h00, 8'h00);
    #1;
    model_eval();
    n_checks++; if (r0_gnt !== 1'b1) $display("FAIL wr_gnt: got %0b want 1", r0_gnt); else n_pass++;
    n_checks++; if (mem_w !== 1'b1) $display("FAIL wr_mem_w: got %0b want 1", mem_w); else n_pass++;
    n_checks++; if (mem_addr !== 8'h10) $display("FAIL wr_mem_addr: got %0h want 10", mem_addr); else n_pass++;
    n_checks++; if (mem_data_in !== 8'hA5) $display("FAIL wr_mem_data: got %0h want a5", mem_data_in); else n_pass++;
    n_checks++; if (r0_rvalid !== exp_rv0) $display("FAIL wr_prev_rvalid: got %0b want %0b", r0_rvalid, exp_rv0); else n_pass++;
    model_commit();
    next_cycle();
    drive0(1'b1, 1'b0, 8'h10, 8'h00);
    #1;
    model_eval();
    n_checks++; if (r0_gnt !== 1'b1) $display("FAIL rd_gnt: got %0b want 1", r0_gnt); else n_pass++;
    n_checks++; if (mem_w !== 1'b0) $display("FAIL rd_mem_w: got %0b want 0", mem_w); else n_pass++;
    n_checks++; if (r0_rvalid !== 1'b0) $display("FAIL rd_rvalid_after_write: got %0b want 0", r0_rvalid); else n_pass++;
    model_commit();
    next_cycle();
    drive0(1'b0, 1'b0, 8'h00, 8'h00);
    #1;
    model_eval();
    n_checks++; if (r0_rvalid !== 1'b1) $display("FAIL rd_rvalid: got %0b want 1", r0_rvalid); else n_pass++;
    n_checks++; if (r0_rdata !== 8'hA5) $display("FAIL rd_rdata: got %0h want a5", r0_rdata); else n_pass++;
    model_commit();
    next_cycle();
    #1;
    n_checks++; if (r0_rvalid !== 1'b0) $display("FAIL rd_rvalid_pulse: got %0b want 0", r0_rvalid); else n_pass++;
    n_checks++; if (r0_rdata !== 8'hA5) $display("FAIL rd_rdata_hold: got %0h want a5", r0_rdata); else n_pass++;
    model_eval();
    model_commit();
    next_cycle();
  endtask

  task automatic test_contention();
    logic prev_g0;
    prev_g0 = 1'b0;
    drive0(1'b1, 1'b0, 8'h20, 8'h00);
    drive1(1'b1, 1'b1, 8'h21, 8'h3C);
    for (int i = 0; i < 8; i++) begin
      #1;
      model_eval();
      n_checks++; if (r0_gnt !== exp_g0) $display("FAIL cont_r0_gnt[%0d]: got %0b want %0b", i, r0_gnt, exp_g0); else n_pass++;
      n_checks++; if (r1_gnt !== exp_g1) $display("FAIL cont_r1_gnt[%0d]: got %0b want %0b", i, r1_gnt, exp_g1); else n_pass++;
      if (i > 0) begin
        n_checks++; if (r0_gnt !== ~prev_g0) $display("FAIL cont_alternate[%0d]: got %0b want %0b", i, r0_gnt, ~prev_g0); else n_pass++;
      end
      n_checks++; if (r1_rvalid !== 1'b0) $display("FAIL cont_r1_rvalid[%0d]: got %0b want 0", i, r1_rvalid); else n_pass++;
      n_checks++; if (r0_rvalid !== exp_rv0) $display("FAIL cont_r0_rvalid[%0d]: got %0b want %0b", i, r0_rvalid, exp_rv0); else n_pass++;
      if (exp_rv0) begin
        n_checks++; if (r0_rdata !== exp_rd0) $display("FAIL cont_r0_rdata[%0d]: got %0h want %0h", i, r0_rdata, exp_rd0); else n_pass++;
      end
      prev_g0 = r0_gnt;
      model_commit();
      @(posedge clk);
    end
    #1;
    drive0(1'b0, 1'b0, 8'h00, 8'h00);
    drive1(1'b0, 1'b0, 8'h00, 8'h00);
    model_eval();
    model_commit();
    next_cycle();
  endtask

  task automatic test_hazard();
    drive1(1'b1, 1'b1, 8'h40, 8'h77);
    #1;
    model_eval();
    n_checks++; if (r1_gnt !== 1'b1) $display("FAIL haz_wr_gnt: got %0b want 1", r1_gnt); else n_pass++;
    model_commit();
    next_cycle();
    drive1(1'b0, 1'b0, 8'h00, 8'h00);
    drive0(1'b1, 1'b0, 8'h40, 8'h00);
    #1;
    model_eval();
    n_checks++; if (r0_gnt !== 1'b1) $display("FAIL haz_rd_gnt: got %0b want 1", r0_gnt); else n_pass++;
    model_commit();
    next_cycle();
    drive0(1'b0, 1'b0, 8'h00, 8'h00);
    #1;
    model_eval();
    n_checks++; if (r0_rvalid !== 1'b1) $display("FAIL haz_rvalid: got %0b want 1", r0_rvalid); else n_pass++;
    n_checks++; if (r0_rdata !== 8'h77) $display("FAIL haz_rdata: got %0h want 77", r0_rdata); else n_pass++;
    model_commit();
    next_cycle();
  endtask

  task automatic test_random();
    bit p0, p1;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    logic [DW-1:0] got;
    p0 = 1'b0; p1 = 1'b0;
    exp_q0.delete(); exp_q1.delete();
    for (int i = 0; i < 401; i++) begin
      // Ungranted requesters keep their request unchanged.
      if (!p0) begin
        if (i < 400 && $urandom_range(0, 2) != 0)
          drive0(1'b1, 1'($urandom_range(0, 1)), AW'(8'h80 + $urandom_range(0, 7)), DW'($urandom_range(0, 255)));
        else drive0(1'b0, 1'b0, AW'($urandom_range(0, 255)), 8'h00);
        p0 = r0_req;
      end
      if (!p1) begin
        if (i < 400 && $urandom_range(0, 2) != 0)
          drive1(1'b1, 1'($urandom_range(0, 1)), AW'(8'h80 + $urandom_range(0, 7)), DW'($urandom_range(0, 255)));
        else drive1(1'b0, 1'b0, AW'($urandom_range(0, 255)), 8'h00);
        p1 = r1_req;
      end
      if (i == 400) begin
        drive0(1'b0, 1'b0, 8'h00, 8'h00);
        drive1(1'b0, 1'b0, 8'h00, 8'h00);
      end
      #1;
      model_eval();
      e_addr = exp_g1 ? r1_addr : r0_addr;
      e_data = (exp_g0 && r0_w) ? r0_wdata : ((exp_g1 && r1_w) ? r1_wdata : 8'h00);
      n_checks++; if (r0_gnt !== exp_g0) $display("FAIL rnd_r0_gnt[%0d]: got %0b want %0b", i, r0_gnt, exp_g0); else n_pass++;
      n_checks++; if (r1_gnt !== exp_g1) $display("FAIL rnd_r1_gnt[%0d]: got %0b want %0b", i, r1_gnt, exp_g1); else n_pass++;
      n_checks++; if (mem_addr !== e_addr) $display("FAIL rnd_mem_addr[%0d]: got %0h want %0h", i, mem_addr, e_addr); else n_pass++;
      n_checks++; if (mem_data_in !== e_data) $display("FAIL rnd_mem_data[%0d]: got %0h want %0h", i, mem_data_in, e_data); else n_pass++;
      n_checks++; if (r0_rvalid !== exp_rv0) $display("FAIL rnd_r0_rvalid[%0d]: got %0b want %0b", i, r0_rvalid, exp_rv0); else n_pass++;
      n_checks++; if (r1_rvalid !== exp_rv1) $display("FAIL rnd_r1_rvalid[%0d]: got %0b want %0b", i, r1_rvalid, exp_rv1); else n_pass++;
      if (r0_rvalid === 1'b1 && exp_q0.size() > 0) begin
        got = exp_q0.pop_front();
        n_checks++; if (r0_rdata !== got) $display("FAIL rnd_r0_rdata[%0d]: got %0h want %0h", i, r0_rdata, got); else n_pass++;
      end
      if (r1_rvalid === 1'b1 && exp_q1.size() > 0) begin
        got = exp_q1.pop_front();
        n_checks++; if (r1_rdata !== got) $display("FAIL rnd_r1_rdata[%0d]: got %0h want %0h", i, r1_rdata, got); else n_pass++;
      end
      model_commit();
      if (exp_rv0) exp_q0.push_back(exp_rd0);
      if (exp_rv1) exp_q1.push_back(exp_rd1);
      if (exp_g0) p0 = 1'b0;
      if (exp_g1) p1 = 1'b0;
      next_cycle();
    end
    n_checks++; if (exp_q0.size() + exp_q1.size() > 1) $display("FAIL rnd_unreturned_reads: got %0d want <=1", exp_q0.size() + exp_q1.size()); else n_pass++;
  endtask

  task automatic test_reset_mid_sweep();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    for (int i = 0; i < 8'h80; i++) begin
      #1;
      n_checks++; if (mem_addr !== AW'(i)) $display("FAIL msw_pre_addr[%0d]: got %0h want %0h", i, mem_addr, i); else n_pass++;
      next_cycle();
    end
    rst = 1'b1;
    #1;
    n_checks++; if (mem_addr === 8'h80 && mem_w !== 1'b0) $display("FAIL msw_reset_mem_w: got %0b want 0", mem_w); else n_pass++;
    next_cycle();
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      n_checks++; if (init_busy !== 1'b1) $display("FAIL msw_busy[%0d]: got %0b want 1", i, init_busy); else n_pass++;
      n_checks++; if (mem_addr !== AW'(i) || mem_w !== 1'b1) $display("FAIL msw_addr[%0d]: got %0h/%0b want %0h/1", i, mem_addr, mem_w, i); else n_pass++;
      next_cycle();
    end
    #1;
    n_checks++; if (init_busy !== 1'b0) $display("FAIL msw_done_busy: got %0b want 0", init_busy); else n_pass++;
    model_zero_mem();
    next_cycle();
  endtask

  task automatic test_reset_mid_read();
    int busy_cycles;
    drive0(1'b1, 1'b1, 8'h33, 8'h5A);
    drive1(1'b0, 1'b0, 8'h00, 8'h00);
    #1; model_eval(); model_commit(); next_cycle();
    drive0(1'b1, 1'b0, 8'h33, 8'h00);
    #1; model_eval();
    n_checks++; if (r0_gnt !== 1'b1) $display("FAIL mrd_gnt: got %0b want 1", r0_gnt); else n_pass++;
    model_commit(); next_cycle();
    drive0(1'b0, 1'b0, 8'h00, 8'h00);
    rst = 1'b1;
    #1;
    n_checks++; if (r0_rvalid !== 1'b1 || r0_rdata !== 8'h5A) $display("FAIL mrd_pre_reset: got %0b/%0h want 1/5a", r0_rvalid, r0_rdata); else n_pass++;
    next_cycle();
    rst = 1'b0;
    model_reset();
    model_zero_mem();
    drive0(1'b1, 1'b0, 8'h33, 8'h00);
    drive1(1'b1, 1'b0, 8'h34, 8'h00);
    #1;
    n_checks++; if (r0_rvalid !== 1'b0) $display("FAIL mrd_rvalid: got %0b want 0", r0_rvalid); else n_pass++;
    n_checks++; if (r0_rdata !== 8'h00) $display("FAIL mrd_rdata: got %0h want 0", r0_rdata); else n_pass++;
    busy_cycles = 0;
    while (init_busy === 1'b1 && busy_cycles < 300) begin
      busy_cycles++;
      @(posedge clk);
      #2;
    end
    n_checks++; if (busy_cycles != DEPTH) $display("FAIL mrd_sweep_len: got %0d want %0d", busy_cycles, DEPTH); else n_pass++;
    model_eval();
    n_checks++; if (r0_gnt !== exp_g0 || r0_gnt !== 1'b1) $display("FAIL mrd_first_tie_r0: got %0b want 1", r0_gnt); else n_pass++;
    n_checks++; if (r1_gnt !== exp_g1 || r1_gnt !== 1'b0) $display("FAIL mrd_first_tie_r1: got %0b want 0", r1_gnt); else n_pass++;
    model_commit();
    @(posedge clk);
    #1;
    drive0(1'b0, 1'b0, 8'h00, 8'h00);
    drive1(1'b0, 1'b0, 8'h00, 8'h00);
    #1;
    n_checks++; if (r0_rvalid !== 1'b1 || r0_rdata !== exp_rd0) $display("FAIL mrd_after_sweep_read: got %0b/%0h want 1/%0h", r0_rvalid, r0_rdata, exp_rd0); else n_pass++;
    next_cycle();
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_clear_sweep();
    test_write_read();
    test_contention();
    test_hazard();
    test_random();
    test_reset_mid_sweep();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Arbitrates the shared 256x8 data memory between two requesters: port 0 is the CPU datapath and port 1 is the I/O or loader side.
- Sits between the requesters and data_memory, and drives its address, data_in and w pins.
- After reset it optionally runs a clear sweep that writes zero to every location before granting any access.
- Memory behaviour it relies on: read is asynchronous, write is synchronous on posedge clk.

Parameters:
- ADDR_W, 8, memory address width; depth is 2^ADDR_W.
- DATA_W, 8, memory word width.
- CLEAR_ON_RESET, 1, 1 runs the zero-fill sweep after reset; 0 starts directly in RUN.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  reset, synchronous, active-high.
- r0_req  input  1  port 0 requests an access this cycle.
- r0_w  input  1  port 0 access is a write (1) or a read (0).
- r0_addr  input  ADDR_W  port 0 address.
- r0_wdata  input  DATA_W  port 0 write data.
- r0_gnt  output  1  port 0 access performed this cycle (combinational).
- r0_rvalid  output  1  pulse: r0_rdata updated by the read granted in the previous cycle.
- r0_rdata  output  DATA_W  last read data returned to port 0 (registered, held).
- r1_req, r1_w, r1_addr, r1_wdata, r1_gnt, r1_rvalid, r1_rdata: same as port 0, for port 1.
- init_busy  output  1  high while the clear sweep runs.
- mem_addr  output  ADDR_W  to data_memory address.
- mem_data_in  output  DATA_W  to data_memory data_in.
- mem_w  output  1  to data_memory w.
- mem_data_out  input  DATA_W  from data_memory data_out (asynchronous read).

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high.
- While rst is high:
  - r0_gnt, r1_gnt and mem_w are 0.
  - r0_rvalid and r1_rvalid reset to 0; r0_rdata and r1_rdata reset to 0.
  - The sweep counter resets to 0 and the last-winner pointer resets to 1.
  - The state goes to CLEAR if CLEAR_ON_RESET=1, otherwise to RUN.
- FSM states are CLEAR and RUN.
- CLEAR state:
  - init_busy=1, mem_w=1, mem_addr=cnt, mem_data_in=0; both gnt are 0 and requests are ignored (not queued).
  - cnt increments each cycle.
  - In the cycle where cnt = 2^ADDR_W-1, the last location is written, the state moves to RUN and cnt wraps to 0.
  - The sweep takes exactly 2^ADDR_W cycles.
- RUN state: init_busy=0. Winner selection is combinational in the same cycle:
  - Only one port requests: that port wins.
  - Both ports request: the port that was not the last winner wins (round-robin).
  - Neither requests: no grant; mem_w=0, mem_addr=r0_addr, mem_data_in=0.
- Granted cycle:
  - rX_gnt=1, mem_addr=rX_addr, mem_w=rX_w, mem_data_in = rX_wdata if a write, else 0.
  - The last-winner pointer updates to X at the clock edge.
- Read latency:
  - For a granted read, mem_data_out is captured into rX_rdata at the edge ending the grant cycle.
  - rX_rvalid=1 for exactly the next cycle; rX_rdata then holds until the next granted read for that port.
  - A granted write never asserts rvalid.
- Ungranted requester: it must hold req, w, addr and wdata stable until it sees gnt. The arbiter keeps no request state.
- With continuous contention, grants alternate every cycle: r0, r1, r0, and so on. Port 0 wins the first tie after reset.
- Read and write to the same address by different ports in consecutive cycles: the read sees the value committed at the prior edge, because the write commits at the end of its grant cycle.
- Back-to-back reads from one port: rvalid stays high every cycle and rdata updates every cycle.
- Reset asserted mid-sweep or mid-RUN: the sweep restarts at address 0, any pending rvalid is dropped and the pointer returns to 1.
- Memory contents outside the sweep are unaffected by reset.

Decomposition:
- Shared package dmem_arb_pkg holds:
  - state encodings ST_CLEAR and ST_RUN;
  - requester IDs REQ_CPU=0 and REQ_AUX=1;
  - default widths ADDR_W=8 and DATA_W=8.
- One sub-module, rr_arb2: a two-way round-robin arbiter.
  - Inputs: req[1:0] and the last-winner pointer.
  - Outputs: one-hot gnt[1:0] and winner id.
  - It owns the pointer register with a synchronous reset to 1.
- dmem_arbiter owns the CLEAR/RUN FSM, the sweep counter, the memory-side muxing and the read-return registers.

Test Plan:
- Clear sweep: rst high for 1 cycle, then low with CLEAR_ON_RESET=1.
  - init_busy is high for exactly 256 cycles; mem_w=1 with addresses 0..255 and data 0.
  - r0_req held high gets no grant until cycle 257.
- Single write then read: r0 writes 0xA5 to address 0x10, then reads 0x10.
  - r0_gnt is high in both cycles.
  - One cycle after the read grant, r0_rvalid=1 and r0_rdata=0xA5.
- Contention: both ports request continuously; r0 reads 0x20 and r1 writes 0x3C to 0x21.
  - Grants go r0, r1, r0, r1 with no cycle lost.
  - r1_rvalid never asserts.
- Cross-port hazard: r1 writes 0x77 to 0x40 in cycle N, r0 reads 0x40 in cycle N+1.
  - r0_rdata=0x77 with r0_rvalid high in cycle N+2.
- Reset mid-sweep: assert rst at sweep address 0x80.
  - After release the sweep restarts at 0 and init_busy is high for a full 256 cycles again.
- Reset mid-read: assert rst in the cycle after a read grant.
  - r0_rvalid=0, r0_rdata=0, and r0 wins the first tie afterwards.
